// File: rtl/jtframe_8751_mbox.sv
// Two-way byte mailbox between the main CPU and the 8751 MCU external-data bus.
// Each direction has a byte latch with full and sticky overrun flags, plus interrupts toward both sides.
module jtframe_8751_mbox #(
  parameter logic [15:0] MCU_ADDR  = 16'h0000,
  parameter int unsigned INT_PULSE = 0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cen,
  input  logic        main_cs,
  input  logic        main_wr,
  input  logic        main_addr,
  input  logic [7:0]  main_dout,
  output logic [7:0]  main_din,
  output logic        main_irq,
  input  logic        mcu_rd,
  input  logic        mcu_wr,
  input  logic [15:0] x_addr,
  input  logic [7:0]  x_dout,
  output logic [7:0]  x_din,
  output logic        int0n
);

  typedef enum logic { EMPTY = 1'b0, FULL = 1'b1 } box_t;

  box_t       m2s_st, m2s_nx, s2m_st, s2m_nx;
  logic [7:0] m2s, s2m;
  logic       ovr_m2s, ovr_s2m;

  // "Seen low" flags: they reset to 0, so a strobe held across reset must
  // drop and rise again before it counts as an access.
  logic main_lo, rd_lo, wr_lo;

  logic main_edge, x_hit;
  logic m2s_load, m2s_drain, s2m_load, s2m_drain, stat_rd;
  logic m2s_ovr_set, s2m_ovr_set;

  assign main_edge = main_cs & main_lo;
  assign x_hit     = (x_addr == MCU_ADDR);

  assign m2s_load  = main_edge &  main_wr & ~main_addr;
  assign s2m_drain = main_edge & ~main_wr & ~main_addr;
  assign stat_rd   = main_edge & ~main_wr &  main_addr;
  assign m2s_drain = cen & mcu_rd & rd_lo & x_hit;
  assign s2m_load  = cen & mcu_wr & wr_lo & x_hit;

  // A concurrent drain frees the slot, so a load in that cycle is no overrun.
  assign m2s_ovr_set = m2s_load & (m2s_st == FULL) & ~m2s_drain;
  assign s2m_ovr_set = s2m_load & (s2m_st == FULL) & ~s2m_drain;

  always_comb begin
    m2s_nx = m2s_st;
    s2m_nx = s2m_st;
    if (m2s_load)       m2s_nx = FULL;
    else if (m2s_drain) m2s_nx = EMPTY;
    if (s2m_load)       s2m_nx = FULL;
    else if (s2m_drain) s2m_nx = EMPTY;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m2s_st <= EMPTY;
      s2m_st <= EMPTY;
    end else begin
      m2s_st <= m2s_nx;
      s2m_st <= s2m_nx;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      main_lo <= 1'b0;
      rd_lo   <= 1'b0;
      wr_lo   <= 1'b0;
    end else begin
      main_lo <= ~main_cs;
      if (cen) begin
        rd_lo <= ~mcu_rd;
        wr_lo <= ~mcu_wr;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m2s     <= '0;
      s2m     <= '0;
      ovr_m2s <= 1'b0;
      ovr_s2m <= 1'b0;
    end else begin
      if (m2s_load) m2s <= main_dout;
      if (s2m_load) s2m <= x_dout;
      ovr_m2s <= (ovr_m2s & ~stat_rd) | m2s_ovr_set;
      ovr_s2m <= (ovr_s2m & ~stat_rd) | s2m_ovr_set;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      main_din <= '0;
      main_irq <= 1'b0;
    end else begin
      main_irq <= (s2m_st == FULL);
      if (s2m_drain)
        main_din <= s2m;
      else if (stat_rd)
        main_din <= {4'b0, ovr_s2m, ovr_m2s, s2m_st == FULL, m2s_st == FULL};
    end
  end

  // Captured byte is held for the whole read; between reads x_din tracks m2s.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x_din <= '0;
    end else if (cen) begin
      if (m2s_drain || !mcu_rd) x_din <= m2s;
    end
  end

  generate
    if (INT_PULSE == 0) begin : g_level
      assign int0n = (m2s_st == EMPTY);
    end else begin : g_pulse
      localparam int unsigned CW = $clog2(INT_PULSE + 1);
      logic [CW-1:0] cnt;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
          cnt <= '0;
        else if (m2s_load)
          cnt <= CW'(INT_PULSE);
        else if (m2s_drain)
          cnt <= '0;
        else if (cen && cnt != '0)
          cnt <= cnt - CW'(1);
      end

      assign int0n = (cnt == '0);
    end
  endgenerate

endmodule
